// File: rtl/ccm_ecc_ctrl.sv
// SECDED ECC controller in front of the 2048x39 CCM SRAM macro.
// Encodes writes, checks/corrects reads, merges partial writes (RMW) and
// optionally scrubs corrected words back into the array.
module ccm_ecc_ctrl #(
   parameter bit          SCRUB_EN = 1'b1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [3:0]       req_be,
   input  logic [10:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_sb_err,
   output logic             rsp_db_err,
   output logic [CNT_W-1:0] sb_err_cnt,
   output logic [10:0]      ram_adr,
   output logic [38:0]      ram_d,
   output logic             ram_we,
   input  logic [38:0]      ram_q
);

   localparam int unsigned AW = 11;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 39;

   typedef enum logic [1:0] {IDLE, RD, RMW, SCRUB} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   lat_addr;
   logic [3:0]      lat_be;
   logic [DW-1:0]   lat_wdata;
   logic [5:0]      syn;
   logic            pm;
   logic            sb_c;
   logic            db_c;
   logic [DW-1:0]   fixed;
   logic [DW-1:0]   be_mask;
   logic [DW-1:0]   merged;

   // Hamming check bits: data bits occupy the non-power-of-two positions 3..38.
   function automatic logic [5:0] hamming_p(input logic [DW-1:0] d);
      logic [5:0] p;
      logic [4:0] k;
      p = '0;
      k = '0;
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            p = p ^ ({6{d[k]}} & 6'(pos));
            k = k + 5'd1;
         end
      end
      return p;
   endfunction

   // Flip the data bit living at Hamming position s (no-op for check-bit positions).
   function automatic logic [DW-1:0] flip_pos(input logic [DW-1:0] d, input logic [5:0] s);
      logic [DW-1:0] r;
      logic [4:0]    k;
      r = d;
      k = '0;
      for (int unsigned pos = 1; pos <= 38; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (6'(pos) == s) r[k] = ~r[k];
            k = k + 5'd1;
         end
      end
      return r;
   endfunction

   // Full codeword: {overall parity, p5..p0, data}.
   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [5:0] p;
      p = hamming_p(d);
      return {^{p, d}, p, d};
   endfunction

   // Check and correct the word coming back from the SRAM.
   always_comb begin
      syn     = hamming_p(ram_q[31:0]) ^ ram_q[37:32];
      pm      = ^ram_q;
      sb_c    = pm && (syn <= 6'd38);
      db_c    = (syn != 6'd0) && !sb_c;
      fixed   = sb_c ? flip_pos(ram_q[31:0], syn) : ram_q[31:0];
      be_mask = {{8{lat_be[3]}}, {8{lat_be[2]}}, {8{lat_be[1]}}, {8{lat_be[0]}}};
      merged  = (lat_wdata & be_mask) | (fixed & ~be_mask);
   end

   // Next state and SRAM pin drive.
   always_comb begin
      state_nxt = state;
      ram_adr   = lat_addr;
      ram_d     = '0;
      ram_we    = 1'b0;
      req_ready = (state == IDLE) && !RST;
      case (state)
         IDLE: begin
            ram_adr = req_addr;
            if (req_valid && !RST) begin
               if (!req_we) begin
                  state_nxt = RD;
               end else if (req_be == 4'hF) begin
                  ram_we = 1'b1;
                  ram_d  = encode(req_wdata);
               end else if (req_be != 4'h0) begin
                  state_nxt = RMW;
               end
            end
         end
         RD: state_nxt = (sb_c && SCRUB_EN) ? SCRUB : IDLE;
         RMW: begin
            state_nxt = IDLE;
            if (!db_c) begin
               ram_we = !RST;
               ram_d  = encode(merged);
            end
         end
         SCRUB: begin
            // rsp_rdata still holds the corrected word from the RD cycle
            state_nxt = IDLE;
            ram_we    = !RST;
            ram_d     = encode(rsp_rdata);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, response pulses and saturating error counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_sb_err <= 1'b0;
         rsp_db_err <= 1'b0;
         sb_err_cnt <= '0;
      end else begin
         state      <= state_nxt;
         rsp_valid  <= 1'b0;
         rsp_sb_err <= 1'b0;
         rsp_db_err <= 1'b0;
         if (state == RD) begin
            rsp_valid  <= 1'b1;
            rsp_rdata  <= fixed;
            rsp_sb_err <= sb_c;
            rsp_db_err <= db_c;
         end
         if (state == RMW) begin
            rsp_sb_err <= sb_c;
            rsp_db_err <= db_c;
         end
         if ((state == RD || state == RMW) && sb_c && (sb_err_cnt != '1))
            sb_err_cnt <= sb_err_cnt + CNT_W'(1);
      end
   end

   // Request latch for RD/RMW/SCRUB follow-up cycles.
   always_ff @(posedge CLK) begin
      if (state == IDLE && req_valid) begin
         lat_addr  <= req_addr;
         lat_be    <= req_be;
         lat_wdata <= req_wdata;
      end
   end

endmodule

// File: tb/tb_ccm_ecc_ctrl.sv
// Directed self-checking bench for ccm_ecc_ctrl with a behavioural SRAM.
module tb_ccm_ecc_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_be;
   logic [10:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_sb_err, rsp_db_err;
   logic [31:0] rsp_rdata;
   logic [1:0]  sb_err_cnt;
   logic [10:0] ram_adr;
   logic [38:0] ram_d, ram_q;
   logic        ram_we;

   logic [38:0] mem [0:2047];
   logic        bd_en = 1'b0;
   logic [10:0] bd_addr = '0;
   logic [38:0] bd_mask = '0;

   int checks = 0;
   int errors = 0;

   ccm_ecc_ctrl #(.SCRUB_EN(1'b1), .CNT_W(2)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_sb_err(rsp_sb_err),
      .rsp_db_err(rsp_db_err), .sb_err_cnt(sb_err_cnt), .ram_adr(ram_adr),
      .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q));

   always #5 CLK = ~CLK;

   // SRAM model with a backdoor bit-flip port
   always @(posedge CLK) begin
      if (bd_en) mem[bd_addr] <= mem[bd_addr] ^ bd_mask;
      else if (ram_we) mem[ram_adr] <= ram_d;
      ram_q <= ram_we ? 'x : mem[ram_adr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic flip(input logic [10:0] a, input logic [38:0] m);
      bd_en = 1'b1; bd_addr = a; bd_mask = m;
      step();
      bd_en = 1'b0;
   endtask

   task automatic rd(input logic [10:0] a, output logic ok, output logic [31:0] d,
                     output logic sb, output logic db, output logic scr);
      logic rdy, v1, v2, v3;
      req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = a; req_wdata = '0;
      @(negedge CLK); rdy = req_ready;
      step(); req_valid = 1'b0;
      @(negedge CLK); v1 = rsp_valid;
      step();
      @(negedge CLK); v2 = rsp_valid; d = rsp_rdata; sb = rsp_sb_err; db = rsp_db_err;
      scr = ram_we && (ram_adr == a);
      step();
      @(negedge CLK); v3 = rsp_valid;
      step();
      ok = rdy && !v1 && v2 && !v3;
   endtask

   task automatic wr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] wd,
                     output logic we0, output logic [38:0] d0, output logic we1,
                     output logic [10:0] a1, output logic db2, output logic v2);
      req_valid = 1'b1; req_we = 1'b1; req_be = be; req_addr = a; req_wdata = wd;
      @(negedge CLK); we0 = ram_we; d0 = ram_d;
      step(); req_valid = 1'b0;
      @(negedge CLK); we1 = ram_we; a1 = ram_adr;
      step();
      @(negedge CLK); db2 = rsp_db_err; v2 = rsp_valid;
      step();
   endtask

   logic ok, sb, db, scr, we0, we1, db2, v2;
   logic [31:0] d;
   logic [38:0] d0, snap;
   logic [10:0] a1;

   task automatic test_reset();
      RST = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
      req_addr = 11'h010; req_wdata = 32'hFFFF_FFFF;
      @(negedge CLK);
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", ram_we); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
      step();
      @(negedge CLK);
      checks++; if ({rsp_valid, rsp_sb_err, rsp_db_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {rsp_valid, rsp_sb_err, rsp_db_err}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
      checks++; if (sb_err_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", sb_err_cnt); end
      RST = 1'b0; req_valid = 1'b0;
      step();
      @(negedge CLK);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
      step();
   endtask

   task automatic test_full_write();
      wr(11'h123, 4'hF, 32'hDEAD_BEEF, we0, d0, we1, a1, db2, v2);
      checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL fw_we got %b want 1", we0); end
      checks++; if (d0[31:0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fw_data got %h want deadbeef", d0[31:0]); end
      checks++; if (we1 !== 1'b0) begin errors++; $display("FAIL fw_single_we got %b want 0", we1); end
      rd(11'h123, ok, d, sb, db, scr);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fw_rd_timing got %b want 1", ok); end
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fw_rd_data got %h want deadbeef", d); end
      checks++; if ({sb, db, scr} !== 3'b000) begin errors++; $display("FAIL fw_rd_flags got %b want 000", {sb, db, scr}); end
      wr(11'h200, 4'hF, 32'h0, we0, d0, we1, a1, db2, v2);
      checks++; if (d0 !== 39'h0) begin errors++; $display("FAIL enc_zero got %h want 0", d0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wv [3];
      logic [38:0] cw [3];
      wv[0] = 32'h0000_0001; cw[0] = 39'h43_0000_0001;
      wv[1] = 32'h8000_0000; cw[1] = 39'h26_8000_0000;
      wv[2] = 32'h0000_0002; cw[2] = 39'h45_0000_0002;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
         req_addr = 11'(11'h100 + i); req_wdata = wv[i];
         @(negedge CLK);
         checks++; if ({req_ready, ram_we} !== 2'b11) begin errors++; $display("FAIL b2b_rdy_we[%0d] got %b want 11", i, {req_ready, ram_we}); end
         checks++; if (ram_d !== cw[i]) begin errors++; $display("FAIL b2b_code[%0d] got %h want %h", i, ram_d, cw[i]); end
         step();
      end
      req_valid = 1'b0;
      step();
   endtask

   task automatic test_noop();
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'h0; req_addr = 11'h077; req_wdata = 32'h1234_5678;
      @(negedge CLK);
      checks++; if ({req_ready, ram_we} !== 2'b10) begin errors++; $display("FAIL noop_accept got %b want 10", {req_ready, ram_we}); end
      step(); req_valid = 1'b0;
      @(negedge CLK);
      checks++; if ({req_ready, ram_we, rsp_valid} !== 3'b100) begin errors++; $display("FAIL noop_idle got %b want 100", {req_ready, ram_we, rsp_valid}); end
      step();
   endtask

   task automatic test_single();
      snap = mem[11'h123];
      flip(11'h123, 39'h20);
      rd(11'h123, ok, d, sb, db, scr);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sb_timing got %b want 1", ok); end
      checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_data got %h want deadbeef", d); end
      checks++; if ({sb, db, scr} !== 3'b101) begin errors++; $display("FAIL sb_flags got %b want 101", {sb, db, scr}); end
      checks++; if (sb_err_cnt !== 2'd1) begin errors++; $display("FAIL sb_cnt got %0d want 1", sb_err_cnt); end
      checks++; if (mem[11'h123] !== snap) begin errors++; $display("FAIL sb_scrubbed got %h want %h", mem[11'h123], snap); end
      rd(11'h123, ok, d, sb, db, scr);
      checks++; if ({ok, sb, db, scr} !== 4'b1000 || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_reread got %b/%h want 1000/deadbeef", {ok, sb, db, scr}, d); end
   endtask

   task automatic test_double();
      flip(11'h123, 39'h10_0008);
      rd(11'h123, ok, d, sb, db, scr);
      checks++; if (d !== 32'hDEBD_BEE7) begin errors++; $display("FAIL db_raw got %h want debdbee7", d); end
      checks++; if ({ok, sb, db, scr} !== 4'b1010) begin errors++; $display("FAIL db_flags got %b want 1010", {ok, sb, db, scr}); end
      checks++; if (sb_err_cnt !== 2'd1) begin errors++; $display("FAIL db_cnt got %0d want 1", sb_err_cnt); end
   endtask

   task automatic test_partial();
      wr(11'h123, 4'hF, 32'hDEAD_BEEF, we0, d0, we1, a1, db2, v2);
      wr(11'h123, 4'b0010, 32'h0000_5500, we0, d0, we1, a1, db2, v2);
      checks++; if ({we0, we1} !== 2'b01) begin errors++; $display("FAIL rmw_we got %b want 01", {we0, we1}); end
      checks++; if (a1 !== 11'h123) begin errors++; $display("FAIL rmw_adr got %h want 123", a1); end
      checks++; if ({db2, v2} !== 2'b00) begin errors++; $display("FAIL rmw_rsp got %b want 00", {db2, v2}); end
      rd(11'h123, ok, d, sb, db, scr);
      checks++; if (d !== 32'hDEAD_55EF) begin errors++; $display("FAIL rmw_data got %h want dead55ef", d); end
      checks++; if ({ok, sb, db, scr} !== 4'b1000) begin errors++; $display("FAIL rmw_clean got %b want 1000", {ok, sb, db, scr}); end
   endtask

   task automatic test_partial_double();
      flip(11'h123, 39'h10_0008);
      snap = mem[11'h123];
      wr(11'h123, 4'b0001, 32'h0000_00AA, we0, d0, we1, a1, db2, v2);
      checks++; if ({we0, we1} !== 2'b00) begin errors++; $display("FAIL rmwdb_we got %b want 00", {we0, we1}); end
      checks++; if ({db2, v2} !== 2'b10) begin errors++; $display("FAIL rmwdb_rsp got %b want 10", {db2, v2}); end
      checks++; if (mem[11'h123] !== snap) begin errors++; $display("FAIL rmwdb_word got %h want %h", mem[11'h123], snap); end
   endtask

   task automatic test_reset_rmw();
      wr(11'h050, 4'hF, 32'h1234_5678, we0, d0, we1, a1, db2, v2);
      req_valid = 1'b1; req_we = 1'b1; req_be = 4'b1100; req_addr = 11'h050; req_wdata = 32'hAAAA_0000;
      step();
      req_valid = 1'b0; RST = 1'b1;
      @(negedge CLK);
      checks++; if ({ram_we, req_ready} !== 2'b00) begin errors++; $display("FAIL rstrmw_we got %b want 00", {ram_we, req_ready}); end
      step(); RST = 1'b0;
      @(negedge CLK);
      checks++; if ({rsp_valid, rsp_sb_err, rsp_db_err, req_ready} !== 4'b0001) begin errors++; $display("FAIL rstrmw_flags got %b want 0001", {rsp_valid, rsp_sb_err, rsp_db_err, req_ready}); end
      checks++; if ({rsp_rdata, sb_err_cnt} !== 34'h0) begin errors++; $display("FAIL rstrmw_regs got %h/%0d want 0/0", rsp_rdata, sb_err_cnt); end
      checks++; if (mem[11'h050][31:0] !== 32'h1234_5678) begin errors++; $display("FAIL rstrmw_word got %h want 12345678", mem[11'h050][31:0]); end
      step();
      rd(11'h050, ok, d, sb, db, scr);
      checks++; if ({ok, sb, db} !== 3'b100 || d !== 32'h1234_5678) begin errors++; $display("FAIL rstrmw_reread got %b/%h want 100/12345678", {ok, sb, db}, d); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_cnt;
      wr(11'h300, 4'hF, 32'hCAFE_F00D, we0, d0, we1, a1, db2, v2);
      for (int i = 0; i < 6; i++) begin
         exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
         flip(11'h300, 39'(1) << (i * 5));
         rd(11'h300, ok, d, sb, db, scr);
         checks++; if ({ok, sb, db} !== 3'b110 || d !== 32'hCAFE_F00D) begin errors++; $display("FAIL sat_rd[%0d] got %b/%h want 110/cafef00d", i, {ok, sb, db}, d); end
         checks++; if (sb_err_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, sb_err_cnt, exp_cnt); end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = '0; req_wdata = '0;
      test_reset();
      test_full_write();
      test_back_to_back();
      test_noop();
      test_single();
      test_double();
      test_partial();
      test_partial_double();
      test_reset_rmw();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
